mem_access_sequencer: RTL and testbench

//  Bus-side sequencer directly upstream of the 1-to-4 chip-select decoder.
//  - Accepts single CPU read/write requests and splits the address into a 2-bit bank number
//    (drives decoder `in`) and an in-bank offset.
//  - Asserts the bank enable (drives decoder `en`) for a fixed, parameterised access window.
//  - Captures read data and signals completion.
//  - One transaction in flight; no queuing.

---
 rtl/mem_access_sequencer.sv | 103 ++++++++++
 tb/tb_mem_access_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: single-transaction bank sequencer feeding a 1-to-4 chip-select decoder; optional BANK_PROTECT_EN blocks bank-0 writes
module mem_access_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              req_ready_o,
  output logic [1:0]        bank_sel_o,
  output logic              bank_en_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q, bank_en_q, mem_we_q, done_q, err_q;
  logic [1:0]        bank_sel_q;
  logic [ADDR_W-3:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rdata_q;
  // Sequencer FSM; every output is a register so the decoder sees glitch-free selects
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      bank_en_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bank_sel_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (req_i) begin
          we_q        <= we_i;
          wdata_q     <= wdata_i;
          req_ready_q <= 1'b0;
`ifdef BANK_PROTECT_EN
          if (we_i && addr_i[ADDR_W-1 -: 2] == 2'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else
`endif
          begin
            state_q    <= SETUP;
            bank_sel_q <= addr_i[ADDR_W-1 -: 2];
            mem_addr_q <= addr_i[ADDR_W-3:0];
            bank_en_q  <= 1'b1;
            cnt_q      <= 4'(WAIT_CYCLES);
          end
        end
        SETUP: begin
          state_q     <= ACCESS;
          mem_we_q    <= we_q;
          mem_wdata_q <= wdata_q;
        end
        ACCESS: if (cnt_q == 4'd0) begin
          if (!we_q) rdata_q <= mem_rdata_i;
          state_q   <= DONE;
          done_q    <= 1'b1;
          bank_en_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o = req_ready_q;
  assign bank_sel_o  = bank_sel_q;
  assign bank_en_o   = bank_en_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_we_o    = mem_we_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: random + directed stimulus against a transaction-timeline model, two instances (WAIT_CYCLES 2 and 0)
module tb_mem_access_sequencer;
  localparam int AW = 10;
  localparam int DW = 8;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wd;} op_t;
  logic clk = 1'b0;
  logic reset, req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, mem_rdata;
  logic ready [2], bank_en [2], mem_we [2], done [2], err [2];
  logic [1:0] bank_sel [2];
  logic [AW-3:0] mem_addr [2];
  logic [DW-1:0] mem_wdata [2], rdata [2];
  int wv [2] = '{2, 0};
  int checks = 0, errors = 0, cyc = 0, rst_cnt = 0;
  bit protect;
  bit m_busy [2], m_we [2], m_prot [2];
  int m_k [2];
  logic [1:0] m_bank [2], e_bsel [2];
  logic [AW-3:0] m_off [2], e_maddr [2];
  logic [DW-1:0] m_wd [2], e_rdata [2], e_wdata [2];
  op_t dq [$] = '{{1'b0, 10'h2A5, 8'h00}, {1'b1, 10'h105, 8'h77}, {1'b1, 10'h010, 8'h5A}, {1'b0, 10'h3C4, 8'h00}};

  mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) u0 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .req_ready_o(ready[0]), .bank_sel_o(bank_sel[0]), .bank_en_o(bank_en[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_we_o(mem_we[0]), .mem_rdata_i(mem_rdata), .rdata_o(rdata[0]),
    .done_o(done[0]), .err_o(err[0]));
  mem_access_sequencer #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0)) u1 (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .req_ready_o(ready[1]), .bank_sel_o(bank_sel[1]), .bank_en_o(bank_en[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_we_o(mem_we[1]), .mem_rdata_i(mem_rdata), .rdata_o(rdata[1]),
    .done_o(done[1]), .err_o(err[1]));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d.%s cycle %0d: got %0h expected %0h", i, tag, cyc, got, exp);
    end
  endtask

  // Expected outputs follow from the cycle index k since acceptance: k=1 select, k=2..W+2 access, k=W+3 done
  task automatic check_outputs(input int i);
    int k = m_k[i];
    int w = wv[i];
    bit b = m_busy[i];
    bit p = m_prot[i];
    chk("req_ready", i, 32'(ready[i]), 32'(!b));
    chk("bank_en", i, 32'(bank_en[i]), 32'(b && !p && k <= w + 2));
    chk("mem_we", i, 32'(mem_we[i]), 32'(b && !p && m_we[i] && k >= 2 && k <= w + 2));
    chk("done", i, 32'(done[i]), 32'(b && (p ? k == 1 : k == w + 3)));
    chk("err", i, 32'(err[i]), 32'(b && p && k == 1));
    chk("bank_sel", i, 32'(bank_sel[i]), 32'(e_bsel[i]));
    chk("mem_addr", i, 32'(mem_addr[i]), 32'(e_maddr[i]));
    chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(e_wdata[i]));
    chk("rdata", i, 32'(rdata[i]), 32'(e_rdata[i]));
  endtask

  task automatic model_step(input int i);
    int w = wv[i];
    if (reset) begin
      m_busy[i] = 0; m_k[i] = 0; m_prot[i] = 0;
      e_bsel[i] = '0; e_maddr[i] = '0; e_wdata[i] = '0; e_rdata[i] = '0;
    end else if (!m_busy[i]) begin
      if (req) begin
        m_busy[i] = 1; m_k[i] = 1; m_we[i] = we;
        m_bank[i] = addr[AW-1:AW-2]; m_off[i] = addr[AW-3:0]; m_wd[i] = wdata;
        m_prot[i] = protect && we && addr[AW-1:AW-2] == 2'd0;
        if (!m_prot[i]) begin e_bsel[i] = m_bank[i]; e_maddr[i] = m_off[i]; end
      end
    end else begin
      if (!m_prot[i] && m_k[i] == 1) e_wdata[i] = m_wd[i];
      if (!m_prot[i] && m_k[i] == w + 2 && !m_we[i]) e_rdata[i] = mem_rdata;
      m_k[i]++;
      if (m_k[i] > (m_prot[i] ? 1 : w + 3)) m_busy[i] = 0;
    end
  endtask

  initial begin
`ifdef BANK_PROTECT_EN
    protect = 1;
`else
    protect = 0;
`endif
    reset = 1; req = 0; we = 0; addr = '0; wdata = '0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    for (int c = 0; c < 2000; c++) begin
      bit acc0;
      @(negedge clk);
      cyc = c;
      for (int i = 0; i < 2; i++) check_outputs(i);
      if (c < 2) begin
        reset = 1; req = 0;
      end else if (c < 120) begin
        reset = 0;
        mem_rdata = 8'h3C;
        req = dq.size() != 0;
        if (req) {we, addr, wdata} = dq[0];
      end else if (c < 160) begin
        reset = 0; req = 1;
        we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); mem_rdata = DW'($urandom);
      end else begin
        if (rst_cnt > 0) begin
          reset = 1; rst_cnt--;
        end else if (m_busy[0] && !m_prot[0] && m_k[0] == 3 && $urandom_range(0, 7) == 0) begin
          reset = 1; rst_cnt = 1;
        end else reset = $urandom_range(0, 199) == 0;
        req = $urandom_range(0, 2) != 0;
        we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom); mem_rdata = DW'($urandom);
      end
      acc0 = !reset && req && !m_busy[0];
      for (int i = 0; i < 2; i++) model_step(i);
      if (c >= 2 && c < 120 && acc0 && dq.size() != 0) void'(dq.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
